// File: rtl/cpu_pkg.sv
// cpu_pkg: state encoding and opcode constants shared by the sequencer and
// the Controller decoder.
//   seq_state_t   : sequencer state encoding (also exported on state_dbg)
//   OP_*          : opcode values of instr[OP_HI:OP_LO]
//   get_opcode()  : extracts the opcode field from an instruction word
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    localparam int OP_HI = 18;
    localparam int OP_LO = 15;

    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    function automatic logic [3:0] get_opcode(input logic [31:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction- and data-memory handshake bundle.
//   imem_addr/imem_req  : fetch address and request (sequencer -> imem)
//   imem_ack/imem_rdata : fetch completion and instruction word (imem -> sequencer)
//   dmem_req/dmem_we    : data access request, 1 = store (sequencer -> dmem)
//   dmem_ack            : data access completion (dmem -> sequencer)
interface cpu_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;

    modport master (
        output imem_addr, imem_req, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_addr, imem_req, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/seq_pc_reg.sv
// seq_pc_reg: program counter with async active-low clear and increment
// enable. Wraps naturally from all-ones to zero.
//   clk, rst_n : clock, async active-low clear
//   inc_en     : advance by one on the next rising edge
//   pc         : current program counter
module seq_pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory/writeback control
// for the 32-bit datapath. Owns the PC (in seq_pc_reg) and the instruction
// register.
//   clk, rst_n : clock, async active-low reset
//   start      : leave IDLE/HALT and begin fetching
//   mem        : instruction/data memory handshakes (master side)
//   instr      : instruction register, feeds the Controller decoder
//   rf_we      : register-file write strobe (WB cycle only)
//   busy       : high outside IDLE and HALT
//   halted     : high in HALT
//   state_dbg  : current state encoding
//
// State  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem request at pc; ack loads ir and bumps pc
// DECODE | one cycle; HALT opcode stops here
// EXEC   | one cycle for the ALU to settle
// MEM    | dmem request; hold until ack
// WB     | one-cycle register-file write
// HALT   | pc frozen after the HALT word; start resumes fetch
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    cpu_sequencer_if.master   mem,
    output logic [31:0]       instr,
    output logic              rf_we,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        state_dbg
);
    seq_state_t      state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic            imem_req_q, imem_req_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic            rf_we_q, rf_we_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            pc_inc;
    logic [PC_W-1:0] pc;
    logic [3:0]      op_q, op_d;

    seq_pc_reg #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (pc_inc),
        .pc     (pc)
    );

    assign op_q = get_opcode(ir_q);
    assign op_d = get_opcode(ir_d);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_inc  = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (mem.imem_ack) begin
                    ir_d    = mem.imem_rdata;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = (op_q == OP_HALT) ? HALT : EXEC;
            EXEC:   state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : WB;
            MEM: begin
                if (mem.dmem_ack) state_d = (op_q == OP_STORE) ? FETCH : WB;
            end
            WB:      state_d = FETCH;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they belong to while staying glitch-free.
        imem_req_d = (state_d == FETCH);
        dmem_req_d = (state_d == MEM);
        dmem_we_d  = (state_d == MEM) && (op_d == OP_STORE);
        rf_we_d    = (state_d == WB);
        busy_d     = (state_d != IDLE) && (state_d != HALT);
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign mem.imem_addr = pc;
    assign mem.imem_req  = imem_req_q;
    assign mem.dmem_req  = dmem_req_q;
    assign mem.dmem_we   = dmem_we_q;
    assign instr         = ir_q;
    assign rf_we         = rf_we_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] instr;
    logic rf_we, busy, halted;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.PC_W(PC_W)) mem_if ();

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem       (mem_if),
        .instr     (instr),
        .rf_we     (rf_we),
        .busy      (busy),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    int tests = 0;
    int failed = 0;

    // memory responders: ack after iw / dw wait cycles of a held request
    logic [31:0] mem [256];
    int iw = 0, dw = 0, icnt = 0, dcnt = 0;
    bit stray_en = 1'b0;

    initial begin
        mem_if.imem_ack   = 1'b0;
        mem_if.imem_rdata = '0;
        mem_if.dmem_ack   = 1'b0;
    end

    always @(negedge clk) begin
        if (stray_en && state_dbg == 3'd3) begin
            mem_if.imem_ack   = 1'b1;
            mem_if.imem_rdata = 32'hDEAD_BEEF;
        end else if (mem_if.imem_req) begin
            if (icnt == iw) begin
                mem_if.imem_ack   = 1'b1;
                mem_if.imem_rdata = mem[mem_if.imem_addr];
                icnt = 0;
            end else begin
                mem_if.imem_ack   = 1'b0;
                mem_if.imem_rdata = 32'hBAD0_BAD0;
                icnt++;
            end
        end else begin
            mem_if.imem_ack = 1'b0;
            icnt = 0;
        end
        if (mem_if.dmem_req) begin
            if (dcnt == dw) begin
                mem_if.dmem_ack = 1'b1;
                dcnt = 0;
            end else begin
                mem_if.dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            mem_if.dmem_ack = 1'b0;
            dcnt = 0;
        end
    end

    // instruction-level model: expands a program into the expected per-cycle outputs
    typedef struct packed {
        logic [2:0]  st;
        logic [7:0]  addr;
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        rf_we;
        logic        busy;
        logic        halted;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    logic [7:0]  m_pc = '0;
    logic [31:0] m_ir = '0;

    task automatic push(input seq_state_t st);
        exp_t e;
        e.st       = st;
        e.addr     = m_pc;
        e.imem_req = (st == FETCH);
        e.dmem_req = (st == MEM);
        e.dmem_we  = (st == MEM) && (m_ir[18:15] == 4'b0110);
        e.rf_we    = (st == WB);
        e.busy     = (st != IDLE) && (st != HALT);
        e.halted   = (st == HALT);
        e.instr    = m_ir;
        q.push_back(e);
    endtask

    task automatic build(input int n, input int iwt, input int dwt, input int halt_tail);
        logic [3:0] op;
        bit done = 1'b0;
        for (int k = 0; k < n && !done; k++) begin
            for (int w = 0; w <= iwt; w++) push(FETCH);
            m_ir = mem[m_pc];
            m_pc = m_pc + 8'd1;
            push(DECODE);
            op = m_ir[18:15];
            if (op == 4'b1111) begin
                for (int t = 0; t < halt_tail; t++) push(HALT);
                done = 1'b1;
            end else begin
                push(EXEC);
                if (op == 4'b0100 || op == 4'b0110) begin
                    for (int w = 0; w <= dwt; w++) push(MEM);
                    if (op == 4'b0100) push(WB);
                end else begin
                    push(WB);
                end
            end
        end
    endtask

    // statistics of the last trace, used for hand-computed literal checks
    int cyc, first_rf, n_rf, n_dreq, n_dwe, fetch2, n_fetch_rise;
    logic prev_req;

    task automatic run_trace();
        exp_t e, g;
        cyc = 0; first_rf = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
        fetch2 = 0; n_fetch_rise = 0; prev_req = 1'b0;
        while (q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            e = q.pop_front();
            g.st = state_dbg; g.addr = mem_if.imem_addr; g.imem_req = mem_if.imem_req;
            g.dmem_req = mem_if.dmem_req; g.dmem_we = mem_if.dmem_we; g.rf_we = rf_we;
            g.busy = busy; g.halted = halted; g.instr = instr;
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL trace cyc=%0d t=%0t got st=%0d addr=%0h ireq=%b dreq=%b we=%b rf=%b busy=%b halt=%b ir=%h exp st=%0d addr=%0h ireq=%b dreq=%b we=%b rf=%b busy=%b halt=%b ir=%h",
                         cyc, $time, g.st, g.addr, g.imem_req, g.dmem_req, g.dmem_we, g.rf_we, g.busy, g.halted, g.instr,
                         e.st, e.addr, e.imem_req, e.dmem_req, e.dmem_we, e.rf_we, e.busy, e.halted, e.instr);
            end
            if (rf_we) begin
                n_rf++;
                if (first_rf == 0) first_rf = cyc;
            end
            if (mem_if.dmem_req) n_dreq++;
            if (mem_if.dmem_req && mem_if.dmem_we) n_dwe++;
            if (mem_if.imem_req && !prev_req) begin
                n_fetch_rise++;
                if (n_fetch_rise == 2) fetch2 = cyc;
            end
            prev_req = mem_if.imem_req;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, rf_we, busy, halted,
                   state_dbg, mem_if.imem_addr}, 32'h0);
        chk({name, "_ir"}, instr, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_state");
        q.delete();
        m_pc = '0;
        m_ir = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // T1: single ALU op then HALT, zero wait
        clear_mem();
        mem[1] = 32'h0007_8000;
        iw = 0; dw = 0;
        do_reset();
        build(2, 0, 0, 3);
        go();
        run_trace();
        chk("alu_rf_we_cycle", first_rf, 4);
        chk("alu_rf_we_count", n_rf, 1);
        chk("alu_next_fetch_cycle", fetch2, 5);
        chk("alu_halt_pc", mem_if.imem_addr, 2);
        chk("alu_halted", halted, 1);

        // T2: LOAD with dmem_ack delayed 3 cycles
        clear_mem();
        mem[0] = 32'h0002_0000;
        mem[1] = 32'h0007_8000;
        iw = 0; dw = 3;
        do_reset();
        build(2, 0, 3, 2);
        go();
        run_trace();
        chk("load_dreq_cycles", n_dreq, 4);
        chk("load_dwe_cycles", n_dwe, 0);
        chk("load_rf_we_cycle", first_rf, 8);
        chk("load_next_fetch_cycle", fetch2, 9);

        // T3: STORE, zero wait
        clear_mem();
        mem[0] = 32'h0003_0000;
        mem[1] = 32'h0007_8000;
        iw = 0; dw = 0;
        do_reset();
        build(2, 0, 0, 2);
        go();
        run_trace();
        chk("store_rf_we_count", n_rf, 0);
        chk("store_dwe_cycles", n_dwe, 1);
        chk("store_next_fetch_cycle", fetch2, 5);

        // T4: HALT at address 2, resume with start, imem waits
        clear_mem();
        mem[1] = 32'h0000_0123;
        mem[2] = 32'h0007_8000;
        mem[3] = 32'h0002_0000;
        mem[4] = 32'h0007_8000;
        iw = 2; dw = 1;
        do_reset();
        build(3, 2, 1, 4);
        go();
        run_trace();
        chk("halt_pc", mem_if.imem_addr, 3);
        chk("halt_no_req", mem_if.imem_req, 0);
        chk("halt_flag", halted, 1);
        build(2, 2, 1, 2);
        go();
        run_trace();
        chk("resume_pc", mem_if.imem_addr, 5);
        chk("resume_ir", instr, 32'h0007_8000);

        // T5: pc wrap at 255, stray imem_ack during every EXEC
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1234;
        mem[255] = 32'h0000_0011;
        iw = 0; dw = 0;
        stray_en = 1'b1;
        do_reset();
        build(256, 0, 0, 0);
        go();
        run_trace();
        chk("wrap_pc", mem_if.imem_addr, 0);
        chk("wrap_ir", instr, 32'h0000_0011);
        build(1, 0, 0, 0);
        run_trace();
        chk("wrap_next_pc", mem_if.imem_addr, 1);
        chk("wrap_next_ir", instr, 32'h0000_1234);
        stray_en = 1'b0;

        // T6: reset while waiting for imem_ack
        clear_mem();
        mem[1] = 32'h0007_8000;
        iw = 5; dw = 0;
        do_reset();
        go();
        @(negedge clk);
        start = 1'b0;
        chk("wait_req", mem_if.imem_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_fetch_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        iw = 0;
        q.delete();
        m_pc = '0;
        m_ir = '0;
        build(2, 0, 0, 2);
        go();
        run_trace();
        chk("restart_halt_pc", mem_if.imem_addr, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
